// File: rtl/store_merge_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : store_merge_unit_pkg                                    |
// | Description : Shared widths, entry record and constants for the      |
// |               store merge unit (write-combining FIFO to the D$).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package store_merge_unit_pkg;

  // Core widths (physical address and register width of the host core).
  localparam int unsigned PLEN          = 56;
  localparam int unsigned XLEN          = 64;
  localparam int unsigned XLEN_BYTES    = XLEN / 8;
  // Entries are tracked at doubleword granularity.
  localparam int unsigned SMU_DW_OFFSET = 3;

  typedef struct packed {
    logic                          valid;
    logic [PLEN-1:SMU_DW_OFFSET]   paddr_dw;
    logic [XLEN-1:0]               data;
    logic [XLEN_BYTES-1:0]         be;
    logic [1:0]                    size;
    logic                          sealed;
  } smu_entry_t;

endpackage
`default_nettype wire

// File: rtl/smu_byte_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : smu_byte_merge                                          |
// | Description : Combinational per-byte merge of a new store into an    |
// |               existing entry; widens size when the lane set grows.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module smu_byte_merge
  import store_merge_unit_pkg::*;
(
  input  logic [XLEN-1:0]       old_data_i,
  input  logic [XLEN_BYTES-1:0] old_be_i,
  input  logic [1:0]            old_size_i,
  input  logic [XLEN-1:0]       new_data_i,
  input  logic [XLEN_BYTES-1:0] new_be_i,
  output logic [XLEN-1:0]       data_o,
  output logic [XLEN_BYTES-1:0] be_o,
  output logic [1:0]            size_o
);

  // Each enabled lane of the new store overwrites the buffered byte.
  for (genvar b = 0; b < int'(XLEN_BYTES); b++) begin : g_byte
    assign data_o[8*b +: 8] = new_be_i[b] ? new_data_i[8*b +: 8] : old_data_i[8*b +: 8];
  end

  assign be_o   = old_be_i | new_be_i;
  // A grown lane set no longer matches the original access size: use full DW.
  assign size_o = (be_o != old_be_i) ? 2'b11 : old_size_i;

endmodule
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : store_merge_unit                                        |
// | Description : Write-combining FIFO between store-buffer commit port  |
// |               and D$ store port. Same-DW stores merge into the tail; |
// |               entries drain in strict FIFO order.                    |
// | Options     : STORE_MERGE_TIMEOUT_EN - lone head waits up to TIMEOUT |
// |               idle cycles for merges before being requested.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  drain_i,
  input  logic                  in_req_i,
  output logic                  in_gnt_o,
  input  logic [PLEN-1:0]       in_paddr_i,
  input  logic [XLEN-1:0]       in_data_i,
  input  logic [XLEN_BYTES-1:0] in_be_i,
  input  logic [1:0]            in_size_i,
  output logic                  out_req_o,
  input  logic                  out_gnt_i,
  output logic [PLEN-1:0]       out_paddr_o,
  output logic [XLEN-1:0]       out_data_o,
  output logic [XLEN_BYTES-1:0] out_be_o,
  output logic [1:0]            out_size_o,
  input  logic [11:0]           page_offset_i,
  output logic                  page_offset_matches_o,
  output logic                  empty_o
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  smu_entry_t        entries_q [DEPTH];
  smu_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  smu_entry_t        head, tail;
  logic              tail_is_head, timeout_hit, merge_hit, alloc, deq;
  logic [XLEN-1:0]       mrg_data;
  logic [XLEN_BYTES-1:0] mrg_be;
  logic [1:0]            mrg_size;
  logic                  unused_lsbs;

  assign unused_lsbs  = ^{in_paddr_i[SMU_DW_OFFSET-1:0], page_offset_i[SMU_DW_OFFSET-1:0]};

  assign tail_ptr     = wr_ptr_q - PTR_W'(1);
  assign head         = entries_q[rd_ptr_q];
  assign tail         = entries_q[tail_ptr];
  assign tail_is_head = (tail_ptr == rd_ptr_q);

`ifdef STORE_MERGE_TIMEOUT_EN
  localparam int unsigned      AGE_W     = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] TIMEOUT_C = AGE_W'(TIMEOUT);
  logic [AGE_W-1:0] age_q, age_d;

  assign timeout_hit = (age_q == TIMEOUT_C);

  // Age of the current head: restarts whenever the head changes or absorbs a merge.
  always_comb begin
    age_d = age_q;
    if ((alloc && count_q == '0) || deq || (merge_hit && tail_is_head)) begin
      age_d = '0;
    end else if (head.valid && age_q != TIMEOUT_C) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Age register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) age_q <= '0;
    else         age_q <= age_d;
  end
`else
  assign timeout_hit = 1'b1;
`endif

  assign out_req_o = head.valid & (head.sealed | (count_q >= CNT_W'(2)) | drain_i | timeout_hit);

  // The last term keeps a head that is being offered to the D$ frozen even in
  // the cycle its request first rises (before the sealed bit is stored); out_gnt_i
  // may arrive in that same cycle and must see the data it was offered.
  assign merge_hit = in_req_i & tail.valid & ~tail.sealed & ~drain_i
                   & (tail.paddr_dw == in_paddr_i[PLEN-1:SMU_DW_OFFSET])
                   & ~(tail_is_head & out_req_o);
  assign alloc     = in_req_i & ~merge_hit & (count_q < DEPTH_C);
  assign in_gnt_o  = merge_hit | alloc;
  assign deq       = out_req_o & out_gnt_i;

  assign out_paddr_o = {head.paddr_dw, {SMU_DW_OFFSET{1'b0}}};
  assign out_data_o  = head.data;
  assign out_be_o    = head.be;
  assign out_size_o  = head.size;
  assign empty_o     = (count_q == '0);

  smu_byte_merge u_byte_merge (
    .old_data_i (tail.data),
    .old_be_i   (tail.be),
    .old_size_i (tail.size),
    .new_data_i (in_data_i),
    .new_be_i   (in_be_i),
    .data_o     (mrg_data),
    .be_o       (mrg_be),
    .size_o     (mrg_size)
  );

  // Load hazard: any buffered entry or the incoming store in the same DW of the page.
  always_comb begin
    page_offset_matches_o = in_req_i & (in_paddr_i[11:3] == page_offset_i[11:3]);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entries_q[i].valid && entries_q[i].paddr_dw[11:3] == page_offset_i[11:3]) begin
        page_offset_matches_o = 1'b1;
      end
    end
  end

  // Next-state: seal/dequeue the head, merge into or allocate at the tail.
  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (out_req_o && !out_gnt_i) begin
      entries_d[rd_ptr_q].sealed = 1'b1;
    end
    if (deq) begin
      entries_d[rd_ptr_q].valid  = 1'b0;
      entries_d[rd_ptr_q].sealed = 1'b0;
      rd_ptr_d                   = rd_ptr_q + PTR_W'(1);
    end
    if (merge_hit) begin
      entries_d[tail_ptr].data = mrg_data;
      entries_d[tail_ptr].be   = mrg_be;
      entries_d[tail_ptr].size = mrg_size;
    end
    if (alloc) begin
      entries_d[wr_ptr_q].valid    = 1'b1;
      entries_d[wr_ptr_q].paddr_dw = in_paddr_i[PLEN-1:SMU_DW_OFFSET];
      entries_d[wr_ptr_q].data     = in_data_i;
      entries_d[wr_ptr_q].be       = in_be_i;
      entries_d[wr_ptr_q].size     = in_size_i;
      entries_d[wr_ptr_q].sealed   = 1'b0;
      wr_ptr_d                     = wr_ptr_q + PTR_W'(1);
    end
    case ({alloc, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_store_merge_unit                                     |
// | Description : Self-checking bench: store vector table, D$ scoreboard |
// |               and hand sequences for full/seal/drain/reset cases.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_store_merge_unit;
  import store_merge_unit_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  drain_i, in_req_i, in_gnt_o, out_req_o, out_gnt_i;
  logic [PLEN-1:0]       in_paddr_i, out_paddr_o;
  logic [XLEN-1:0]       in_data_i, out_data_o;
  logic [XLEN_BYTES-1:0] in_be_i, out_be_o;
  logic [1:0]            in_size_i, out_size_o;
  logic [11:0]           page_offset_i;
  logic                  page_offset_matches_o, empty_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_deq    = 0;

  typedef struct packed {
    logic [PLEN-1:0]       paddr;
    logic [XLEN-1:0]       data;
    logic [XLEN_BYTES-1:0] be;
    logic [1:0]            size;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [PLEN-1:0]       paddr;
    logic [XLEN-1:0]       data;
    logic [XLEN_BYTES-1:0] be;
    logic [1:0]            size;
    logic                  exp_gnt;
  } vec_t;
  vec_t vecs[8];

  always #5 clk_i = ~clk_i;

  store_merge_unit #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .drain_i               (drain_i),
    .in_req_i              (in_req_i),
    .in_gnt_o              (in_gnt_o),
    .in_paddr_i            (in_paddr_i),
    .in_data_i             (in_data_i),
    .in_be_i               (in_be_i),
    .in_size_i             (in_size_i),
    .out_req_o             (out_req_o),
    .out_gnt_i             (out_gnt_i),
    .out_paddr_o           (out_paddr_o),
    .out_data_o            (out_data_o),
    .out_be_o              (out_be_o),
    .out_size_o            (out_size_o),
    .page_offset_i         (page_offset_i),
    .page_offset_matches_o (page_offset_matches_o),
    .empty_o               (empty_o)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // D$ side: every accepted write is compared against the oldest expected one.
  always @(negedge clk_i) begin
    if (rst_ni && out_req_o && out_gnt_i) begin
      n_deq++;
      if (sb.size() == 0) begin
        check("dcache_unexpected_write", {72'd0, out_paddr_o}, 128'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dcache_paddr", {72'd0, out_paddr_o}, {72'd0, e.paddr});
        check("dcache_data",  {64'd0, out_data_o},  {64'd0, e.data});
        check("dcache_be",    {120'd0, out_be_o},   {120'd0, e.be});
        check("dcache_size",  {126'd0, out_size_o}, {126'd0, e.size});
      end
    end
  end

  task automatic push(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                      input logic [XLEN_BYTES-1:0] be, input logic [1:0] sz);
    exp_t e;
    e.paddr = a; e.data = d; e.be = be; e.size = sz;
    sb.push_back(e);
  endtask

  // Present a store from posedge+1; in_gnt_o is checked at the negedge. The
  // request stays high across the next posedge (the accepting edge).
  task automatic store(input string name, input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                       input logic [XLEN_BYTES-1:0] be, input logic [1:0] sz, input logic exp_gnt);
    @(posedge clk_i); #1;
    in_req_i = 1'b1; in_paddr_i = a; in_data_i = d; in_be_i = be; in_size_i = sz;
    @(negedge clk_i);
    check(name, {127'd0, in_gnt_o}, {127'd0, exp_gnt});
  endtask

  task automatic release_req();
    @(posedge clk_i); #1;
    in_req_i = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    @(negedge clk_i);
    while (!out_req_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!out_req_o) check("wait_out_req_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_empty(input string name);
    int n;
    @(posedge clk_i); #1;
    out_gnt_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!empty_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check(name, {127'd0, empty_o}, 128'd1);
    check({name, "_sb_drained"}, 128'(sb.size()), 128'd0);
    @(posedge clk_i); #1;
    out_gnt_i = 1'b0;
  endtask

  initial begin
    int lat, exp_lat, deq0, tries;

    vecs[0] = '{56'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'd3, 1'b1};
    vecs[1] = '{56'h1000, 64'h0000_0000_0000_0011, 8'h01, 2'd0, 1'b1};
    vecs[2] = '{56'h1001, 64'h0000_0000_0000_2200, 8'h02, 2'd0, 1'b1};
    vecs[3] = '{56'h1003, 64'h0000_0000_4400_0000, 8'h08, 2'd0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      vecs[4+i] = '{56'h3000 + PLEN'(8*i), 64'hC0DE_0000 + XLEN'(i), 8'hFF, 2'd3, 1'b1};
    end

    rst_ni = 1'b0; drain_i = 1'b0; in_req_i = 1'b0; out_gnt_i = 1'b0;
    in_paddr_i = '0; in_data_i = '0; in_be_i = '0; in_size_i = '0; page_offset_i = '0;

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_out_req", {127'd0, out_req_o}, 128'd0);
    check("reset_empty",   {127'd0, empty_o},   128'd1);
    check("reset_in_gnt",  {127'd0, in_gnt_o},  128'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // First write, D$ always granting; head request latency depends on the timeout option.
`ifdef STORE_MERGE_TIMEOUT_EN
    exp_lat = TIMEOUT;
`else
    exp_lat = 0;
`endif
    @(posedge clk_i); #1;
    out_gnt_i = 1'b1;
    store("first_gnt", 56'h8000_0010, 64'hAA, 8'h01, 2'd0, 1'b1);
    push(56'h8000_0010, 64'hAA, 8'h01, 2'd0);
    release_req();
    wait_req(lat);
    check("first_req_latency", 128'(lat), 128'(exp_lat));
    wait_empty("first_drained");

    // Merge: a blocker head, then three byte stores to one DW merge into the tail.
    deq0 = n_deq;
    push(vecs[0].paddr, vecs[0].data, vecs[0].be, vecs[0].size);
    push(56'h1000, 64'h0000_0000_4400_2211, 8'h0B, 2'd3);
    for (int i = 0; i < 4; i++) begin
      store($sformatf("merge_gnt_%0d", i), vecs[i].paddr, vecs[i].data, vecs[i].be,
            vecs[i].size, vecs[i].exp_gnt);
    end
    release_req();
    wait_req(lat);
    check("merge_head_paddr", {72'd0, out_paddr_o}, 128'h2000);
    check("merge_not_empty", {127'd0, empty_o}, 128'd0);
    wait_empty("merge_drained");
    check("merge_dcache_writes", 128'(n_deq - deq0), 128'd2);

    // Full: DEPTH distinct DWs, the next miss waits until one entry leaves.
    for (int i = 4; i < 8; i++) begin
      store($sformatf("full_fill_gnt_%0d", i - 4), vecs[i].paddr, vecs[i].data, vecs[i].be,
            vecs[i].size, vecs[i].exp_gnt);
      push(vecs[i].paddr, vecs[i].data, vecs[i].be, vecs[i].size);
    end
    store("full_refused", 56'h3020, 64'h5555, 8'hFF, 2'd3, 1'b0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("full_refused_hold", {127'd0, in_gnt_o}, 128'd0);
    @(posedge clk_i); #1;
    out_gnt_i = 1'b1;
    @(negedge clk_i);
    check("full_refused_during_deq", {127'd0, in_gnt_o}, 128'd0);
    @(posedge clk_i); #1;
    out_gnt_i = 1'b0;
    @(negedge clk_i);
    check("full_granted_after_deq", {127'd0, in_gnt_o}, 128'd1);
    push(56'h3020, 64'h5555, 8'hFF, 2'd3);
    release_req();
    wait_empty("full_drained");

    // Seal stability: requested head holds while D$ stalls; same-DW store allocates.
    store("seal_first_gnt", 56'h4000, 64'hAB, 8'h01, 2'd0, 1'b1);
    push(56'h4000, 64'hAB, 8'h01, 2'd0);
    release_req();
    wait_req(lat);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("seal_req_%0d", i),   {127'd0, out_req_o},  128'd1);
      check($sformatf("seal_paddr_%0d", i), {72'd0, out_paddr_o}, 128'h4000);
      check($sformatf("seal_data_%0d", i),  {64'd0, out_data_o},  128'hAB);
      check($sformatf("seal_be_%0d", i),    {120'd0, out_be_o},   128'h01);
      @(negedge clk_i);
    end
    store("seal_second_gnt", 56'h4001, 64'hCD00, 8'h02, 2'd0, 1'b1);
    push(56'h4000, 64'hCD00, 8'h02, 2'd0);
    release_req();
    @(negedge clk_i);
    check("seal_head_be_unmerged", {120'd0, out_be_o}, 128'h01);
    check("seal_head_still_req", {127'd0, out_req_o}, 128'd1);
    wait_empty("seal_drained");

    // Ordering across pointer wrap with a randomly stalling D$.
    deq0 = n_deq;
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        @(posedge clk_i); #1;
        in_req_i = 1'b1; in_paddr_i = 56'h5000 + PLEN'(8*i);
        in_data_i = 64'h5A00 + XLEN'(i); in_be_i = 8'hFF; in_size_i = 2'd3;
        out_gnt_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        tries++;
      end while (!in_gnt_o && tries < 200);
      check($sformatf("order_gnt_%0d", i), {127'd0, in_gnt_o}, 128'd1);
      if (in_gnt_o) push(56'h5000 + PLEN'(8*i), 64'h5A00 + XLEN'(i), 8'hFF, 2'd3);
    end
    release_req();
    wait_empty("order_drained");
    check("order_dcache_writes", 128'(n_deq - deq0), 128'd10);

    // Drain and load hazard against the second buffered entry.
    store("hazard_a_gnt", 56'h6010, 64'h1, 8'hFF, 2'd3, 1'b1);
    push(56'h6010, 64'h1, 8'hFF, 2'd3);
    store("hazard_b_gnt", 56'h6128, 64'h2, 8'hFF, 2'd3, 1'b1);
    push(56'h6128, 64'h2, 8'hFF, 2'd3);
    release_req();
    page_offset_i = 12'h128;
    drain_i = 1'b1;
    @(negedge clk_i);
    check("hazard_match_two", {127'd0, page_offset_matches_o}, 128'd1);
    check("hazard_drain_req", {127'd0, out_req_o}, 128'd1);
    @(posedge clk_i); #1;
    out_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    out_gnt_i = 1'b0;
    @(negedge clk_i);
    check("hazard_match_one", {127'd0, page_offset_matches_o}, 128'd1);
    check("hazard_head_b", {72'd0, out_paddr_o}, 128'h6128);
    check("hazard_not_empty", {127'd0, empty_o}, 128'd0);
    @(posedge clk_i); #1;
    out_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    out_gnt_i = 1'b0;
    @(negedge clk_i);
    check("hazard_match_none", {127'd0, page_offset_matches_o}, 128'd0);
    check("hazard_empty", {127'd0, empty_o}, 128'd1);
    // Incoming request alone raises the hazard combinationally.
    @(posedge clk_i); #1;
    in_req_i = 1'b1; in_paddr_i = 56'h7128;
    @(negedge clk_i);
    check("hazard_match_incoming", {127'd0, page_offset_matches_o}, 128'd1);
    #1;
    in_req_i = 1'b0;
    drain_i = 1'b0;

    // Asynchronous reset while the head is being offered.
    store("rst_mid_gnt", 56'h7000, 64'h77, 8'h01, 2'd0, 1'b1);
    release_req();
    wait_req(lat);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_out_req", {127'd0, out_req_o}, 128'd0);
    check("rst_mid_empty", {127'd0, empty_o}, 128'd1);
    sb.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_mid_stays_idle", {127'd0, out_req_o}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
